// File: rtl/sc_axiip_pkg.sv
// rtl/sc_axiip_pkg.sv - shared arbiter state and register-bus type definitions
// Used by sc_axiip_rrarb and sc_axiip_regarb.

package sc_axiip_pkg;

    localparam int REG_TYP_W = 10;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // {burst[9:8], count[7:0]}; an all-zero TYP marks the final beat of a transfer
    typedef struct packed {
        logic [1:0] burst;
        logic [7:0] count;
    } reg_typ_t;

    function automatic logic typ_is_final(input reg_typ_t typ);
        return (typ == '0);
    endfunction

endpackage

// File: rtl/sc_axiip_rrarb.sv
// rtl/sc_axiip_rrarb.sv - 2-way round-robin arbiter holding a lock until the final beat
// Optional wait timeout compiled in with SC_AXIIP_REGARB_TIMEOUT_EN.

module sc_axiip_rrarb
    import sc_axiip_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       m_en_i,
    input  logic       m_wat_i,
    input  reg_typ_t   m_typ_i,
    output logic       lock_o,
    output logic       gnt_o,
    output logic       tmo_o
);

    arb_state_e state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       ptr_q, ptr_d;
    logic       beat;
    logic       last_beat;
    logic       tmo;

    assign beat      = (state_q == ARB_LOCK) && m_en_i && !m_wat_i;
    assign last_beat = beat && typ_is_final(m_typ_i);

`ifdef SC_AXIIP_REGARB_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Fires on the wait cycle that brings the consecutive-wait run up to TIMEOUT_CYCLES
    assign tmo = (state_q == ARB_LOCK) && m_wat_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if ((state_q != ARB_LOCK) || !m_wat_i || tmo) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (|req_i) begin
                    state_d = ARB_LOCK;
                    gnt_d   = (&req_i) ? ptr_q : req_i[1];
                end
            end
            ARB_LOCK: begin
                if (last_beat || tmo) begin
                    state_d = ARB_IDLE;
                    ptr_d   = ~gnt_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            gnt_q   <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign lock_o = (state_q == ARB_LOCK);
    assign gnt_o  = gnt_q;
    assign tmo_o  = tmo;

endmodule

// File: rtl/sc_axiip_regarb.sv
// rtl/sc_axiip_regarb.sv - two-requester register bus arbiter, independent write and read paths
// Optional wait timeout compiled in with SC_AXIIP_REGARB_TIMEOUT_EN.

module sc_axiip_regarb
    import sc_axiip_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_BYTE  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                         AXI_CLK,
    input  logic                         AXI_RESETN,

    input  logic [AXI_ADDR_WIDTH-1:0]    S0_REG_WADR,
    input  logic [REG_TYP_W-1:0]         S0_REG_WTYP,
    input  logic [AXI_DATA_BYTE-1:0]     S0_REG_WENB,
    input  logic [AXI_DATA_BYTE*8-1:0]   S0_REG_WDAT,
    output logic                         S0_REG_WWAT,
    output logic                         S0_REG_WERR,
    input  logic [AXI_ADDR_WIDTH-1:0]    S0_REG_RADR,
    input  logic [REG_TYP_W-1:0]         S0_REG_RTYP,
    input  logic                         S0_REG_RENB,
    output logic [AXI_DATA_BYTE*8-1:0]   S0_REG_RDAT,
    output logic                         S0_REG_RWAT,
    output logic                         S0_REG_RERR,

    input  logic [AXI_ADDR_WIDTH-1:0]    S1_REG_WADR,
    input  logic [REG_TYP_W-1:0]         S1_REG_WTYP,
    input  logic [AXI_DATA_BYTE-1:0]     S1_REG_WENB,
    input  logic [AXI_DATA_BYTE*8-1:0]   S1_REG_WDAT,
    output logic                         S1_REG_WWAT,
    output logic                         S1_REG_WERR,
    input  logic [AXI_ADDR_WIDTH-1:0]    S1_REG_RADR,
    input  logic [REG_TYP_W-1:0]         S1_REG_RTYP,
    input  logic                         S1_REG_RENB,
    output logic [AXI_DATA_BYTE*8-1:0]   S1_REG_RDAT,
    output logic                         S1_REG_RWAT,
    output logic                         S1_REG_RERR,

    output logic [AXI_ADDR_WIDTH-1:0]    M_REG_WADR,
    output logic [REG_TYP_W-1:0]         M_REG_WTYP,
    output logic [AXI_DATA_BYTE-1:0]     M_REG_WENB,
    output logic [AXI_DATA_BYTE*8-1:0]   M_REG_WDAT,
    input  logic                         M_REG_WWAT,
    input  logic                         M_REG_WERR,
    output logic [AXI_ADDR_WIDTH-1:0]    M_REG_RADR,
    output logic [REG_TYP_W-1:0]         M_REG_RTYP,
    output logic                         M_REG_RENB,
    input  logic [AXI_DATA_BYTE*8-1:0]   M_REG_RDAT,
    input  logic                         M_REG_RWAT,
    input  logic                         M_REG_RERR
);

    logic w_lock, w_gnt, w_tmo;
    logic r_lock, r_gnt, r_tmo;

    // Write path
    sc_axiip_rrarb #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_warb (
        .clk_i   (AXI_CLK),
        .rst_ni  (AXI_RESETN),
        .req_i   ({|S1_REG_WENB, |S0_REG_WENB}),
        .m_en_i  (|M_REG_WENB),
        .m_wat_i (M_REG_WWAT),
        .m_typ_i (reg_typ_t'(M_REG_WTYP)),
        .lock_o  (w_lock),
        .gnt_o   (w_gnt),
        .tmo_o   (w_tmo)
    );

    assign M_REG_WADR = w_gnt ? S1_REG_WADR : S0_REG_WADR;
    assign M_REG_WTYP = w_gnt ? S1_REG_WTYP : S0_REG_WTYP;
    assign M_REG_WDAT = w_gnt ? S1_REG_WDAT : S0_REG_WDAT;
    assign M_REG_WENB = !w_lock ? '0 : (w_gnt ? S1_REG_WENB : S0_REG_WENB);

    // A timeout completes the stalled beat locally with an error
    assign S0_REG_WWAT = (w_lock && !w_gnt) ? (M_REG_WWAT & ~w_tmo) : 1'b1;
    assign S0_REG_WERR = (w_lock && !w_gnt) ? (M_REG_WERR |  w_tmo) : 1'b0;
    assign S1_REG_WWAT = (w_lock &&  w_gnt) ? (M_REG_WWAT & ~w_tmo) : 1'b1;
    assign S1_REG_WERR = (w_lock &&  w_gnt) ? (M_REG_WERR |  w_tmo) : 1'b0;

    // Read path
    sc_axiip_rrarb #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rarb (
        .clk_i   (AXI_CLK),
        .rst_ni  (AXI_RESETN),
        .req_i   ({S1_REG_RENB, S0_REG_RENB}),
        .m_en_i  (M_REG_RENB),
        .m_wat_i (M_REG_RWAT),
        .m_typ_i (reg_typ_t'(M_REG_RTYP)),
        .lock_o  (r_lock),
        .gnt_o   (r_gnt),
        .tmo_o   (r_tmo)
    );

    assign M_REG_RADR = r_gnt ? S1_REG_RADR : S0_REG_RADR;
    assign M_REG_RTYP = r_gnt ? S1_REG_RTYP : S0_REG_RTYP;
    assign M_REG_RENB = r_lock && (r_gnt ? S1_REG_RENB : S0_REG_RENB);

    assign S0_REG_RDAT = M_REG_RDAT;
    assign S1_REG_RDAT = M_REG_RDAT;

    assign S0_REG_RWAT = (r_lock && !r_gnt) ? (M_REG_RWAT & ~r_tmo) : 1'b1;
    assign S0_REG_RERR = (r_lock && !r_gnt) ? (M_REG_RERR |  r_tmo) : 1'b0;
    assign S1_REG_RWAT = (r_lock &&  r_gnt) ? (M_REG_RWAT & ~r_tmo) : 1'b1;
    assign S1_REG_RERR = (r_lock &&  r_gnt) ? (M_REG_RERR |  r_tmo) : 1'b0;

endmodule

// File: tb/tb_sc_axiip_regarb.sv
// tb/tb_sc_axiip_regarb.sv - self-checking bench for sc_axiip_regarb
// Timeout scenario active with SC_AXIIP_REGARB_TIMEOUT_EN.

module tb_sc_axiip_regarb;

`ifdef SC_AXIIP_REGARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [31:0] s_wadr [2];
    logic [9:0]  s_wtyp [2];
    logic [3:0]  s_wenb [2];
    logic [31:0] s_wdat [2];
    logic [31:0] s_radr [2];
    logic [9:0]  s_rtyp [2];
    logic        s_renb [2];

    logic        m_wwat, m_werr, m_rwat, m_rerr;
    logic [31:0] m_rdat;

    logic        s0_wwat, s0_werr, s1_wwat, s1_werr;
    logic [31:0] s0_rdat, s1_rdat;
    logic        s0_rwat, s0_rerr, s1_rwat, s1_rerr;
    logic [31:0] m_wadr, m_wdat, m_radr;
    logic [9:0]  m_wtyp, m_rtyp;
    logic [3:0]  m_wenb;
    logic        m_renb;

    int checks = 0;
    int errors = 0;

    // Behavioural model: owner of each bus (-1 = free), round-robin pointer, wait run length
    int w_own = -1, r_own = -1;
    int w_ptr = 0,  r_ptr = 0;
    int w_cnt = 0,  r_cnt = 0;

    sc_axiip_regarb #(
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_BYTE  (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .AXI_CLK     (clk),
        .AXI_RESETN  (rst_n),
        .S0_REG_WADR (s_wadr[0]), .S0_REG_WTYP (s_wtyp[0]), .S0_REG_WENB (s_wenb[0]),
        .S0_REG_WDAT (s_wdat[0]), .S0_REG_WWAT (s0_wwat),   .S0_REG_WERR (s0_werr),
        .S0_REG_RADR (s_radr[0]), .S0_REG_RTYP (s_rtyp[0]), .S0_REG_RENB (s_renb[0]),
        .S0_REG_RDAT (s0_rdat),   .S0_REG_RWAT (s0_rwat),   .S0_REG_RERR (s0_rerr),
        .S1_REG_WADR (s_wadr[1]), .S1_REG_WTYP (s_wtyp[1]), .S1_REG_WENB (s_wenb[1]),
        .S1_REG_WDAT (s_wdat[1]), .S1_REG_WWAT (s1_wwat),   .S1_REG_WERR (s1_werr),
        .S1_REG_RADR (s_radr[1]), .S1_REG_RTYP (s_rtyp[1]), .S1_REG_RENB (s_renb[1]),
        .S1_REG_RDAT (s1_rdat),   .S1_REG_RWAT (s1_rwat),   .S1_REG_RERR (s1_rerr),
        .M_REG_WADR  (m_wadr),    .M_REG_WTYP  (m_wtyp),    .M_REG_WENB  (m_wenb),
        .M_REG_WDAT  (m_wdat),    .M_REG_WWAT  (m_wwat),    .M_REG_WERR  (m_werr),
        .M_REG_RADR  (m_radr),    .M_REG_RTYP  (m_rtyp),    .M_REG_RENB  (m_renb),
        .M_REG_RDAT  (m_rdat),    .M_REG_RWAT  (m_rwat),    .M_REG_RERR  (m_rerr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit w_timeout();
        return TMO_EN && (w_own >= 0) && m_wwat && (w_cnt == TMO - 1);
    endfunction

    function automatic bit r_timeout();
        return TMO_EN && (r_own >= 0) && m_rwat && (r_cnt == TMO - 1);
    endfunction

    task automatic model_reset();
        w_own = -1; r_own = -1;
        w_ptr = 0;  r_ptr = 0;
        w_cnt = 0;  r_cnt = 0;
    endtask

    task automatic model_step();
        bit wt, rt, beat;
        wt = w_timeout();
        rt = r_timeout();
        if (w_own < 0) begin
            if ((s_wenb[0] != 0) && (s_wenb[1] != 0)) w_own = w_ptr;
            else if (s_wenb[0] != 0)                  w_own = 0;
            else if (s_wenb[1] != 0)                  w_own = 1;
            w_cnt = 0;
        end else begin
            beat = (s_wenb[w_own] != 0) && !m_wwat;
            if (wt || (beat && s_wtyp[w_own] == 0)) begin
                w_ptr = 1 - w_own; w_own = -1; w_cnt = 0;
            end else w_cnt = m_wwat ? w_cnt + 1 : 0;
        end
        if (r_own < 0) begin
            if (s_renb[0] && s_renb[1]) r_own = r_ptr;
            else if (s_renb[0])         r_own = 0;
            else if (s_renb[1])         r_own = 1;
            r_cnt = 0;
        end else begin
            beat = s_renb[r_own] && !m_rwat;
            if (rt || (beat && s_rtyp[r_own] == 0)) begin
                r_ptr = 1 - r_own; r_own = -1; r_cnt = 0;
            end else r_cnt = m_rwat ? r_cnt + 1 : 0;
        end
    endtask

    task automatic compare_all();
        bit wt, rt;
        logic act_wwat [2], act_werr [2], act_rwat [2], act_rerr [2];
        wt = w_timeout();
        rt = r_timeout();
        act_wwat = '{s0_wwat, s1_wwat};
        act_werr = '{s0_werr, s1_werr};
        act_rwat = '{s0_rwat, s1_rwat};
        act_rerr = '{s0_rerr, s1_rerr};
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("s%0d_wwat", n), act_wwat[n], (w_own == n) ? (m_wwat && !wt) : 1'b1);
            chk($sformatf("s%0d_werr", n), act_werr[n], (w_own == n) ? (m_werr || wt)  : 1'b0);
            chk($sformatf("s%0d_rwat", n), act_rwat[n], (r_own == n) ? (m_rwat && !rt) : 1'b1);
            chk($sformatf("s%0d_rerr", n), act_rerr[n], (r_own == n) ? (m_rerr || rt)  : 1'b0);
        end
        chk("s0_rdat", s0_rdat, m_rdat);
        chk("s1_rdat", s1_rdat, m_rdat);
        if (w_own < 0) chk("m_wenb_idle", m_wenb, 0);
        else begin
            chk("m_wenb", m_wenb, s_wenb[w_own]);
            chk("m_wadr", m_wadr, s_wadr[w_own]);
            chk("m_wtyp", m_wtyp, s_wtyp[w_own]);
            chk("m_wdat", m_wdat, s_wdat[w_own]);
        end
        if (r_own < 0) chk("m_renb_idle", m_renb, 0);
        else begin
            chk("m_renb", m_renb, s_renb[r_own]);
            chk("m_radr", m_radr, s_radr[r_own]);
            chk("m_rtyp", m_rtyp, s_rtyp[r_own]);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
    end

    initial forever begin
        @(negedge clk);
        compare_all();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int n = 0; n < 2; n++) begin
            s_wadr[n] = 32'h0; s_wtyp[n] = 10'h0; s_wenb[n] = 4'h0; s_wdat[n] = 32'h0;
            s_radr[n] = 32'h0; s_rtyp[n] = 10'h0; s_renb[n] = 1'b0;
        end
        m_wwat = 1'b0; m_werr = 1'b0; m_rwat = 1'b0; m_rerr = 1'b0; m_rdat = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step(); step();
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        do_reset();
        @(negedge clk);
        chk("rst_m_wenb", m_wenb, 4'h0);
        chk("rst_m_renb", m_renb, 1'b0);
        chk("rst_s0_wwat", s0_wwat, 1'b1);
        chk("rst_s1_rwat", s1_rwat, 1'b1);
        chk("rst_s0_werr", s0_werr, 1'b0);

        // Single write from S0
        step();
        s_wenb[0] = 4'hF; s_wtyp[0] = 10'h0; s_wadr[0] = 32'h100; s_wdat[0] = 32'hA5A5_0001;
        @(negedge clk);
        chk("single_latency_wenb", m_wenb, 4'h0);
        step();
        @(negedge clk);
        chk("single_m_wenb", m_wenb, 4'hF);
        chk("single_s0_wwat", s0_wwat, 1'b0);
        chk("single_m_wadr", m_wadr, 32'h100);
        step();
        // Pointer now 1: simultaneous request should favour S1
        s_wenb[0] = 4'hF; s_wadr[0] = 32'h200;
        s_wenb[1] = 4'h3; s_wadr[1] = 32'h300; s_wtyp[1] = 10'h0;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("ptr1_m_wadr", m_wadr, 32'h300);
        chk("ptr1_s0_wwat", s0_wwat, 1'b1);
        step();
        s_wenb[1] = 4'h0;
        @(negedge clk);
        chk("ptr1_gap_wenb", m_wenb, 4'h0);
        step();
        @(negedge clk);
        chk("ptr1_then_s0", m_wadr, 32'h200);
        step();
        s_wenb[0] = 4'h0;

        // Both request from reset: S0 first
        do_reset();
        s_wenb[0] = 4'hF; s_wadr[0] = 32'h200;
        s_wenb[1] = 4'hF; s_wadr[1] = 32'h300;
        step();
        @(negedge clk);
        chk("both_first_s0", m_wadr, 32'h200);
        chk("both_s1_wwat_held", s1_wwat, 1'b1);
        step();
        s_wenb[0] = 4'h0;
        @(negedge clk);
        chk("both_gap_wenb", m_wenb, 4'h0);
        step();
        @(negedge clk);
        chk("both_then_s1", m_wadr, 32'h300);
        chk("both_s1_wwat", s1_wwat, 1'b0);
        step();
        s_wenb[1] = 4'h0;

        // S1 4-beat read burst, S0 competing, S1 drops enable once mid-burst
        step();
        s_renb[1] = 1'b1; s_rtyp[1] = 10'h103; s_radr[1] = 32'h40; m_rdat = 32'h1234_5678;
        step();
        s_renb[0] = 1'b1; s_radr[0] = 32'h80;
        @(negedge clk);
        chk("burst_b0_rtyp", m_rtyp, 10'h103);
        chk("burst_b0_s0_rwat", s0_rwat, 1'b1);
        chk("burst_rdat_bcast", s0_rdat, 32'h1234_5678);
        step();
        s_rtyp[1] = 10'h102; s_renb[1] = 1'b0;
        @(negedge clk);
        chk("burst_drop_renb", m_renb, 1'b0);
        chk("burst_drop_s0_rwat", s0_rwat, 1'b1);
        step();
        s_renb[1] = 1'b1;
        @(negedge clk);
        chk("burst_b1_rtyp", m_rtyp, 10'h102);
        step();
        s_rtyp[1] = 10'h101;
        @(negedge clk);
        chk("burst_b2_s0_rwat", s0_rwat, 1'b1);
        step();
        s_rtyp[1] = 10'h000;
        @(negedge clk);
        chk("burst_b3_rtyp", m_rtyp, 10'h000);
        chk("burst_b3_s1_rwat", s1_rwat, 1'b0);
        chk("burst_b3_s0_rwat", s0_rwat, 1'b1);
        step();
        s_renb[1] = 1'b0;
        @(negedge clk);
        chk("burst_after_renb", m_renb, 1'b0);
        step();
        @(negedge clk);
        chk("burst_s0_served", s0_rwat, 1'b0);
        chk("burst_s0_radr", m_radr, 32'h80);
        step();
        s_renb[0] = 1'b0;

        // S0 write and S1 read together
        step();
        s_wenb[0] = 4'h5; s_wtyp[0] = 10'h0; s_renb[1] = 1'b1; s_rtyp[1] = 10'h0;
        step();
        @(negedge clk);
        chk("par_s0_wwat", s0_wwat, 1'b0);
        chk("par_s1_rwat", s1_rwat, 1'b0);
        step();
        s_wenb[0] = 4'h0; s_renb[1] = 1'b0;
        @(negedge clk);
        chk("par_done_wenb", m_wenb, 4'h0);
        chk("par_done_renb", m_renb, 1'b0);

        // Reset asserted mid-lock while downstream is waiting
        step();
        s_wenb[0] = 4'hF; s_wtyp[0] = 10'h101; s_wadr[0] = 32'h500; m_wwat = 1'b1;
        step();
        @(negedge clk);
        chk("lock_wait_wenb", m_wenb, 4'hF);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_wenb", m_wenb, 4'h0);
        chk("async_rst_s0_wwat", s0_wwat, 1'b1);
        chk("async_rst_s0_werr", s0_werr, 1'b0);
        step();
        s_wtyp[0] = 10'h0; m_wwat = 1'b0;
        s_wenb[1] = 4'hF; s_wadr[1] = 32'h600;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_no_beat", m_wenb, 4'h0);
        step();
        @(negedge clk);
        chk("post_rst_ptr0", m_wadr, 32'h500);
        step();
        s_wenb[0] = 4'h0; s_wenb[1] = 4'h0;
        step(); step();

`ifdef SC_AXIIP_REGARB_TIMEOUT_EN
        // Read stalls forever: timeout completes it with an error
        s_renb[0] = 1'b1; s_rtyp[0] = 10'h0; m_rwat = 1'b1;
        step();
        for (int i = 1; i < TMO; i++) begin
            @(negedge clk);
            chk("tmo_wait_rwat", s0_rwat, 1'b1);
            chk("tmo_wait_rerr", s0_rerr, 1'b0);
            step();
        end
        @(negedge clk);
        chk("tmo_fire_rwat", s0_rwat, 1'b0);
        chk("tmo_fire_rerr", s0_rerr, 1'b1);
        step();
        s_renb[0] = 1'b0;
        @(negedge clk);
        chk("tmo_idle_renb", m_renb, 1'b0);
        chk("tmo_idle_rerr", s0_rerr, 1'b0);
        m_rwat = 1'b0;
        step();
`endif

        // Randomised traffic checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int n = 0; n < 2; n++) begin
                s_wenb[n] = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                s_wtyp[n] = $urandom_range(0, 1) ? 10'h0 : 10'($urandom);
                s_wadr[n] = $urandom;
                s_wdat[n] = $urandom;
                s_renb[n] = 1'($urandom_range(0, 1));
                s_rtyp[n] = $urandom_range(0, 1) ? 10'h0 : 10'($urandom);
                s_radr[n] = $urandom;
            end
            m_wwat = ($urandom_range(0, 2) == 0);
            m_rwat = ($urandom_range(0, 2) == 0);
            m_werr = 1'($urandom_range(0, 1));
            m_rerr = 1'($urandom_range(0, 1));
            m_rdat = $urandom;
            rst_n  = ($urandom_range(0, 399) != 0);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
